// File: rtl/router_out_reader.sv
// Packet sink for one router output port: drains the port FIFO before the
// router's no-read timeout, forwards payload bytes and checks parity/address.
module router_out_reader #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter logic [1:0]  PORT_ADDR   = 2'b00,
    parameter int unsigned START_DELAY = 0
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  vld_out,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  soft_reset,
    input  logic                  sink_ready,
    output logic                  read_enb,
    output logic [DATA_WIDTH-1:0] pkt_data,
    output logic                  pkt_data_valid,
    output logic                  pkt_done,
    output logic                  pkt_err,
    output logic                  addr_err,
    output logic                  pkt_abort,
    output logic [5:0]            pkt_len,
    output logic [15:0]           pkt_count
);

    localparam int unsigned LEN_W  = 6;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned DLY_W  = 6;
    localparam int unsigned PCNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_HDR_REQ,
        S_HDR_CAP,
        S_BODY,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [DLY_W-1:0]        dly_q, dly_d;
    logic [CNT_W-1:0]        issued_q, issued_d;
    logic [CNT_W-1:0]        rcvd_q, rcvd_d;
    logic                    cap_q, cap_d;
    logic [DATA_WIDTH-1:0]   acc_q, acc_d;
    logic [1:0]              addr_q, addr_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    data_vld_q, data_vld_d;
    logic                    done_q, done_d;
    logic                    perr_q, perr_d;
    logic                    aerr_q, aerr_d;
    logic                    abort_q, abort_d;
    logic [PCNT_W-1:0]       count_q, count_d;

    logic [CNT_W-1:0]        total_c;
    logic                    read_enb_c;

    // Reads still owed in the body: payload bytes plus the parity byte.
    assign total_c = CNT_W'(len_q) + CNT_W'(1);

    // FIFO read request must follow vld_out in the same cycle so it never
    // fires on an empty FIFO.
    always_comb begin
        read_enb_c = 1'b0;
        case (state_q)
            S_HDR_REQ: read_enb_c = vld_out;
            S_BODY:    read_enb_c = vld_out & sink_ready & (issued_q < total_c);
            default:   read_enb_c = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        issued_d   = issued_q;
        rcvd_d     = rcvd_q;
        cap_d      = read_enb_c & ~soft_reset;
        acc_d      = acc_q;
        addr_d     = addr_q;
        len_d      = len_q;
        data_d     = data_q;
        data_vld_d = 1'b0;
        done_d     = 1'b0;
        perr_d     = perr_q;
        aerr_d     = aerr_q;
        abort_d    = 1'b0;
        count_d    = count_q;

        case (state_q)
            S_IDLE: begin
                if (vld_out && !soft_reset) begin
                    if (START_DELAY == 0) begin
                        state_d = S_HDR_REQ;
                    end else begin
                        dly_d   = DLY_W'(START_DELAY);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (soft_reset) begin
                    state_d = S_IDLE;
                end else if (dly_q <= DLY_W'(1)) begin
                    dly_d   = '0;
                    state_d = S_HDR_REQ;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            S_HDR_REQ: begin
                if (soft_reset) begin
                    state_d = S_IDLE;
                    abort_d = 1'b1;
                end else if (vld_out) begin
                    state_d = S_HDR_CAP;
                end
            end
            S_HDR_CAP: begin
                if (soft_reset) begin
                    state_d = S_IDLE;
                    abort_d = 1'b1;
                end else begin
                    len_d    = data_out[7:2];
                    addr_d   = data_out[1:0];
                    acc_d    = data_out;
                    issued_d = '0;
                    rcvd_d   = '0;
                    state_d  = S_BODY;
                end
            end
            S_BODY: begin
                if (soft_reset) begin
                    state_d = S_IDLE;
                    abort_d = 1'b1;
                end else begin
                    if (read_enb_c) begin
                        issued_d = issued_q + CNT_W'(1);
                    end
                    if (cap_q) begin
                        acc_d  = acc_q ^ data_out;
                        rcvd_d = rcvd_q + CNT_W'(1);
                        // The byte after the last payload byte is parity.
                        if (rcvd_q == CNT_W'(len_q)) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            perr_d  = ((acc_q ^ data_out) != '0);
                            aerr_d  = (addr_q != PORT_ADDR);
                            count_d = count_q + PCNT_W'(1);
                        end else begin
                            data_d     = data_out;
                            data_vld_d = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                if (vld_out && (START_DELAY == 0)) begin
                    state_d = S_HDR_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            dly_q      <= '0;
            issued_q   <= '0;
            rcvd_q     <= '0;
            cap_q      <= 1'b0;
            acc_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            data_q     <= '0;
            data_vld_q <= 1'b0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
            aerr_q     <= 1'b0;
            abort_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            issued_q   <= issued_d;
            rcvd_q     <= rcvd_d;
            cap_q      <= cap_d;
            acc_q      <= acc_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            data_q     <= data_d;
            data_vld_q <= data_vld_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
            aerr_q     <= aerr_d;
            abort_q    <= abort_d;
            count_q    <= count_d;
        end
    end

    assign read_enb       = read_enb_c;
    assign pkt_data       = data_q;
    assign pkt_data_valid = data_vld_q;
    assign pkt_done       = done_q;
    assign pkt_err        = perr_q;
    assign addr_err       = aerr_q;
    assign pkt_abort      = abort_q;
    assign pkt_len        = len_q;
    assign pkt_count      = count_q;

endmodule

// File: tb/tb_router_out_reader.sv
// Directed bench for router_out_reader: FIFO model feeds packets, a scoreboard
// holds expected payload bytes and completion records.
module tb_router_out_reader;

    typedef struct packed {
        logic        perr;
        logic        aerr;
        logic [5:0]  len;
        logic [15:0] cnt;
    } done_t;

    logic        clock;
    logic        resetn;
    logic        vld_out, soft_reset, sink_ready;
    logic [7:0]  data_out;
    logic        read_enb, pkt_data_valid, pkt_done, pkt_err, addr_err, pkt_abort;
    logic [7:0]  pkt_data;
    logic [5:0]  pkt_len;
    logic [15:0] pkt_count;

    logic        vld2, srst2;
    logic [7:0]  data2;
    logic        read_enb2, pkt_data_valid2, pkt_done2, pkt_err2, addr_err2, pkt_abort2;
    logic [7:0]  pkt_data2;
    logic [5:0]  pkt_len2;
    logic [15:0] pkt_count2;

    logic [7:0]  fifo[$];
    logic [7:0]  exp_data[$];
    done_t       exp_done[$];
    logic        vld_en;
    logic        rd_s, rd2_s;
    logic [9:0]  rd_tr, dv_tr, dn_tr;
    int          n_chk, n_err;
    int          n_rd, n_rd2, n_done, n_done2, n_abort, n_abort2;
    int          model_count;

    router_out_reader #(.DATA_WIDTH(8), .PORT_ADDR(2'b01), .START_DELAY(0)) u_dut (
        .clock(clock), .resetn(resetn), .vld_out(vld_out), .data_out(data_out),
        .soft_reset(soft_reset), .sink_ready(sink_ready), .read_enb(read_enb),
        .pkt_data(pkt_data), .pkt_data_valid(pkt_data_valid), .pkt_done(pkt_done),
        .pkt_err(pkt_err), .addr_err(addr_err), .pkt_abort(pkt_abort),
        .pkt_len(pkt_len), .pkt_count(pkt_count)
    );

    router_out_reader #(.DATA_WIDTH(8), .PORT_ADDR(2'b01), .START_DELAY(40)) u_dut_dly (
        .clock(clock), .resetn(resetn), .vld_out(vld2), .data_out(data2),
        .soft_reset(srst2), .sink_ready(1'b1), .read_enb(read_enb2),
        .pkt_data(pkt_data2), .pkt_data_valid(pkt_data_valid2), .pkt_done(pkt_done2),
        .pkt_err(pkt_err2), .addr_err(addr_err2), .pkt_abort(pkt_abort2),
        .pkt_len(pkt_len2), .pkt_count(pkt_count2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs mid-cycle, then advance the FIFO model.
    task automatic tick();
        done_t e;
        vld_out = vld_en && (fifo.size() != 0);
        @(negedge clock);
        rd_s  = read_enb;
        rd2_s = read_enb2;
        rd_tr = {rd_tr[8:0], read_enb};
        dv_tr = {dv_tr[8:0], pkt_data_valid};
        dn_tr = {dn_tr[8:0], pkt_done};
        if (read_enb) begin
            n_rd++;
            chk("rd_while_empty", 32'(vld_out), 32'd1);
        end
        if (read_enb2) begin
            n_rd2++;
            chk("rd2_while_empty", 32'(vld2), 32'd1);
        end
        if (pkt_data_valid) begin
            if (exp_data.size() == 0) chk("unexpected_data", 32'(pkt_data_valid), 32'd0);
            else chk("pkt_data", 32'(pkt_data), 32'(exp_data.pop_front()));
        end
        if (pkt_done) begin
            n_done++;
            if (exp_done.size() == 0) chk("unexpected_done", 32'(pkt_done), 32'd0);
            else begin
                e = exp_done.pop_front();
                chk("done_pkt_err", 32'(pkt_err), 32'(e.perr));
                chk("done_addr_err", 32'(addr_err), 32'(e.aerr));
                chk("done_pkt_len", 32'(pkt_len), 32'(e.len));
                chk("done_pkt_count", 32'(pkt_count), 32'(e.cnt));
            end
        end
        if (pkt_abort)  n_abort++;
        if (pkt_abort2) n_abort2++;
        if (pkt_done2)  n_done2++;
        @(posedge clock);
        #1;
        if (rd_s && fifo.size() != 0) data_out = fifo.pop_front();
        vld_out = vld_en && (fifo.size() != 0);
    endtask

    task automatic expect_pkt(input logic [7:0] hdr, input int n, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] par);
        logic [7:0] pl[3];
        logic [7:0] acc;
        done_t      e;
        pl[0] = b0; pl[1] = b1; pl[2] = b2;
        acc = hdr;
        for (int i = 0; i < n; i++) begin
            exp_data.push_back(pl[i]);
            acc = acc ^ pl[i];
        end
        acc = acc ^ par;
        model_count++;
        e.perr = (acc != 8'h00);
        e.aerr = (hdr[1:0] != 2'b01);
        e.len  = hdr[7:2];
        e.cnt  = 16'(model_count);
        exp_done.push_back(e);
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input int n, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] par);
        logic [7:0] pl[3];
        pl[0] = b0; pl[1] = b1; pl[2] = b2;
        expect_pkt(hdr, n, b0, b1, b2, par);
        fifo.push_back(hdr);
        for (int i = 0; i < n; i++) fifo.push_back(pl[i]);
        fifo.push_back(par);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int i;
        d0 = n_done;
        i = 0;
        while (n_done == d0 && i < budget) begin
            tick();
            i++;
        end
        chk(tag, 32'(n_done), 32'(d0 + 1));
    endtask

    initial begin
        int r0, a0, d0, cnt;
        n_chk = 0; n_err = 0; n_rd = 0; n_rd2 = 0;
        n_done = 0; n_done2 = 0; n_abort = 0; n_abort2 = 0; model_count = 0;
        resetn = 1'b0; vld_en = 1'b1; sink_ready = 1'b1; soft_reset = 1'b0;
        data_out = 8'h00; vld_out = 1'b0; vld2 = 1'b0; srst2 = 1'b0; data2 = 8'h01;
        rd_s = 1'b0; rd2_s = 1'b0; rd_tr = '0; dv_tr = '0; dn_tr = '0;

        repeat (3) tick();
        chk("rst_outputs", {pkt_data, pkt_data_valid, pkt_done, pkt_err, addr_err, pkt_abort, read_enb},
            32'd0);
        chk("rst_pkt_len", 32'(pkt_len), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        resetn = 1'b1;
        repeat (2) tick();

        // Clean packet with back-to-back FIFO data.
        send_pkt(8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h0D);
        repeat (10) tick();
        chk("t1_read_enb_pattern", 32'(rd_tr), 32'(10'b0101111000));
        chk("t1_valid_pattern", 32'(dv_tr), 32'(10'b0000011100));
        chk("t1_done_pattern", 32'(dn_tr), 32'(10'b0000000010));

        // Bad parity byte still forwards payload; error holds afterwards.
        send_pkt(8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h0C);
        wait_done("t2_done_timeout", 30);
        repeat (3) tick();
        chk("t2_err_hold", 32'(pkt_err), 32'd1);

        // Zero-length packet: header then parity only.
        send_pkt(8'h01, 0, 8'h00, 8'h00, 8'h00, 8'h01);
        wait_done("len0_done_timeout", 30);

        // Wrong destination address.
        send_pkt(8'h0E, 3, 8'h11, 8'h22, 8'h33, 8'h0E);
        wait_done("t3_done_timeout", 30);
        tick();
        chk("t3_aerr_hold", 32'(addr_err), 32'd1);

        // FIFO runs empty after byte 22, then the sink stalls.
        expect_pkt(8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h0D);
        fifo.push_back(8'h0D); fifo.push_back(8'h11); fifo.push_back(8'h22);
        repeat (10) tick();
        r0 = n_rd;
        repeat (5) tick();
        chk("t4_no_rd_while_empty", 32'(n_rd), 32'(r0));
        sink_ready = 1'b0;
        fifo.push_back(8'h33); fifo.push_back(8'h0D);
        r0 = n_rd;
        repeat (3) tick();
        chk("t4_no_rd_sink_stall", 32'(n_rd), 32'(r0));
        sink_ready = 1'b1;
        d0 = n_done;
        wait_done("t4_done_timeout", 30);
        repeat (4) tick();
        chk("t4_single_done", 32'(n_done), 32'(d0 + 1));

        // Start delay of 40, soft reset during the wait.
        vld2 = 1'b1;
        repeat (30) tick();
        chk("t5_no_rd_in_delay", 32'(n_rd2), 32'd0);
        srst2 = 1'b1;
        tick();
        srst2 = 1'b0; vld2 = 1'b0;
        repeat (5) tick();
        chk("t5_no_rd_after_srst", 32'(n_rd2), 32'd0);
        chk("t5_no_abort", 32'(n_abort2), 32'd0);
        chk("t5_no_done", 32'(n_done2), 32'd0);
        vld2 = 1'b1;
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (rd2_s) break;
            cnt++;
        end
        chk("t5_start_latency", 32'(cnt), 32'd41);
        srst2 = 1'b1; vld2 = 1'b0;
        tick();
        srst2 = 1'b0;
        repeat (3) tick();
        chk("t5_hdr_abort", 32'(n_abort2), 32'd1);
        chk("t5_dly_outputs", {pkt_data2, pkt_data_valid2, pkt_err2, addr_err2, pkt_len2, pkt_done2},
            32'd0);
        chk("t5_dly_count", 32'(pkt_count2), 32'd0);

        // Soft reset after the second payload byte.
        exp_data.push_back(8'h11); exp_data.push_back(8'h22);
        fifo.push_back(8'h0D); fifo.push_back(8'h11); fifo.push_back(8'h22);
        repeat (12) tick();
        a0 = n_abort; d0 = n_done;
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        fifo.delete();
        repeat (4) tick();
        chk("t6_abort_once", 32'(n_abort), 32'(a0 + 1));
        chk("t6_no_done", 32'(n_done), 32'(d0));
        chk("t6_count_kept", 32'(pkt_count), 32'(model_count));

        // Asynchronous reset while the header is being captured.
        fifo.push_back(8'h0D); fifo.push_back(8'h11); fifo.push_back(8'h22);
        fifo.push_back(8'h33); fifo.push_back(8'h0D);
        rd_s = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rd_s) break;
        end
        chk("t6_hdr_read_seen", 32'(rd_s), 32'd1);
        resetn = 1'b0;
        #1;
        chk("t6_async_rst_outputs",
            {pkt_data, pkt_data_valid, pkt_done, pkt_err, addr_err, pkt_abort, read_enb}, 32'd0);
        chk("t6_async_rst_len", 32'(pkt_len), 32'd0);
        chk("t6_async_rst_count", 32'(pkt_count), 32'd0);
        fifo.delete();
        model_count = 0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        send_pkt(8'h0D, 3, 8'hA5, 8'h5A, 8'hFF, 8'h0D ^ 8'hA5 ^ 8'h5A ^ 8'hFF);
        wait_done("post_rst_done_timeout", 30);
        repeat (3) tick();

        chk("sb_data_drained", 32'(exp_data.size()), 32'd0);
        chk("sb_done_drained", 32'(exp_done.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
